// File: rtl/cvp14_pkg.sv
// Shared constants for the vector datapath: lane geometry, FP16 field layout,
// opcode encodings and the VST serializer state type.
package cvp14_pkg;

    localparam int LANES      = 16;
    localparam int LANE_W     = 16;
    localparam int VEC_W      = 256;
    localparam int ADDR_W     = 16;
    localparam int LANE_IDX_W = $clog2(LANES);

    localparam int FP16_SIGN_BIT = 15;
    localparam int FP16_EXP_MSB  = 14;
    localparam int FP16_EXP_LSB  = 10;
    localparam int FP16_MAN_MSB  = 9;
    localparam int FP16_MAN_LSB  = 0;

    localparam logic [3:0] OP_VADD = 4'b0000;
    localparam logic [3:0] OP_VDOT = 4'b0001;
    localparam logic [3:0] OP_SMUL = 4'b0010;
    localparam logic [3:0] OP_SST  = 4'b0011;
    localparam logic [3:0] OP_VLD  = 4'b0100;
    localparam logic [3:0] OP_VST  = 4'b0101;
    localparam logic [3:0] OP_SLL  = 4'b0110;
    localparam logic [3:0] OP_SLH  = 4'b0111;
    localparam logic [3:0] OP_J    = 4'b1000;
    localparam logic [3:0] OP_NOP  = 4'b1111;

    typedef enum logic [1:0] {
        VST_IDLE  = 2'd0,
        VST_ISSUE = 2'd1,
        VST_DONE  = 2'd2
    } vst_state_t;

    // Index of the lowest set bit; 0 when the mask is empty.
    function automatic logic [LANE_IDX_W-1:0] lowest_lane(input logic [LANES-1:0] mask);
        lowest_lane = '0;
        for (int i = LANES - 1; i >= 0; i--) begin
            if (mask[i]) begin
                lowest_lane = LANE_IDX_W'(i);
            end
        end
    endfunction

endpackage

// File: rtl/vst_serializer_lane_find.sv
// Priority encoder: lowest set mask bit strictly above the current lane.
module vst_lane_find
    import cvp14_pkg::*;
(
    input  logic [LANES-1:0]      mask,
    input  logic [LANE_IDX_W-1:0] cur,
    output logic [LANE_IDX_W-1:0] next_lane,
    output logic                  any
);

    always_comb begin
        next_lane = '0;
        any       = 1'b0;
        for (int i = LANES - 1; i >= 0; i--) begin
            if (mask[i] && (i > int'(cur))) begin
                next_lane = LANE_IDX_W'(i);
                any       = 1'b1;
            end
        end
    end

endmodule

// File: rtl/vst_serializer.sv
// Vector store serializer: latches one result vector and writes each enabled
// lane to memory as a single 16-bit req/ack transaction, in ascending lane order.
//
//   state     | meaning
//   ----------+----------------------------------------------------------
//   VST_IDLE  | in_ready high, waiting for a vector
//   VST_ISSUE | mem_req held on the current lane until mem_ack
//   VST_DONE  | one-cycle done pulse, new vectors refused
module vst_serializer
    import cvp14_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [VEC_W-1:0]  in_vec,
    input  logic [ADDR_W-1:0] in_base,
    input  logic [LANES-1:0]  in_mask,
    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [LANE_W-1:0] mem_wdata,
    input  logic              mem_ack,
    output logic              busy,
    output logic              done
);

    vst_state_t state_q, state_d;

    logic [VEC_W-1:0]      vec_q,  vec_d;
    logic [ADDR_W-1:0]     base_q, base_d;
    logic [LANES-1:0]      mask_q, mask_d;
    logic [LANE_IDX_W-1:0] lane_q, lane_d;

    logic                  req_d;
    logic [ADDR_W-1:0]     addr_d;
    logic [LANE_W-1:0]     wdata_d;
    logic                  busy_d;
    logic                  done_d;

    logic [LANE_IDX_W-1:0] next_lane;
    logic                  any_next;

    vst_lane_find u_lane_find (
        .mask      (mask_q),
        .cur       (lane_q),
        .next_lane (next_lane),
        .any       (any_next)
    );

    assign in_ready = (state_q == VST_IDLE);
    assign mem_we   = mem_req;

    always_comb begin
        state_d = state_q;
        vec_d   = vec_q;
        base_d  = base_q;
        mask_d  = mask_q;
        lane_d  = lane_q;

        case (state_q)
            VST_IDLE: begin
                if (in_valid) begin
                    vec_d  = in_vec;
                    base_d = in_base;
                    mask_d = in_mask;
                    lane_d = lowest_lane(in_mask);
                    if (in_mask != '0) begin
                        state_d = VST_ISSUE;
                    end else begin
                        state_d = VST_DONE;
                    end
                end
            end
            VST_ISSUE: begin
                if (mem_ack) begin
                    mask_d = mask_q & ~(LANES'(1) << lane_q);
                    if (any_next) begin
                        lane_d = next_lane;
                    end else begin
                        state_d = VST_DONE;
                    end
                end
            end
            VST_DONE: begin
                state_d = VST_IDLE;
            end
            default: begin
                state_d = VST_IDLE;
            end
        endcase

        // Outputs are computed from the next state so they can be registered
        // without adding a cycle of latency to the bus.
        req_d   = (state_d == VST_ISSUE);
        addr_d  = req_d ? (base_d + ADDR_W'(lane_d)) : '0;
        wdata_d = req_d ? vec_d[int'(lane_d) * LANE_W +: LANE_W] : '0;
        busy_d  = (state_d != VST_IDLE);
        done_d  = (state_d == VST_DONE);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q   <= VST_IDLE;
            vec_q     <= '0;
            base_q    <= '0;
            mask_q    <= '0;
            lane_q    <= '0;
            mem_req   <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
            busy      <= 1'b0;
            done      <= 1'b0;
        end else begin
            state_q   <= state_d;
            vec_q     <= vec_d;
            base_q    <= base_d;
            mask_q    <= mask_d;
            lane_q    <= lane_d;
            mem_req   <= req_d;
            mem_addr  <= addr_d;
            mem_wdata <= wdata_d;
            busy      <= busy_d;
            done      <= done_d;
        end
    end

endmodule
